// File: rtl/pwm_duty_gen.sv
// rtl/pwm_duty_gen.sv - fixed-period PWM with push-button duty step up/down
module pwm_duty_gen #(
    parameter int PERIOD      = 10,
    parameter int DUTY_INIT   = 5,
    parameter int DUTY_STEP   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic increse_duty,
    input  logic decrease_duty,
    output logic pwm_out
);

    localparam int DW = $clog2(PERIOD + 1);
    localparam int CW = $clog2(PERIOD);

    localparam logic [DW:0]   STEP_W   = (DW + 1)'(DUTY_STEP);
    localparam logic [DW:0]   PERIOD_W = (DW + 1)'(PERIOD);
    localparam logic [DW-1:0] PERIOD_N = DW'(PERIOD);
    localparam logic [DW-1:0] INIT_N   = DW'(DUTY_INIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [SYNC_STAGES-1:0] inc_sync;
    logic [SYNC_STAGES-1:0] dec_sync;
    logic                   inc_prev;
    logic                   dec_prev;
    logic                   inc_pulse;
    logic                   dec_pulse;

    logic [DW-1:0] duty_req;
    logic [DW-1:0] duty_req_next;
    logic [DW-1:0] duty_active;
    logic [DW-1:0] duty_active_next;
    logic [DW:0]   inc_sum;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          wrap;

    // Synchronise both request inputs and keep the previous synchronised value for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_sync <= '0;
            dec_sync <= '0;
            inc_prev <= 1'b0;
            dec_prev <= 1'b0;
        end else begin
            inc_sync[0] <= increse_duty;
            dec_sync[0] <= decrease_duty;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                inc_sync[i] <= inc_sync[i-1];
                dec_sync[i] <= dec_sync[i-1];
            end
            inc_prev <= inc_sync[SYNC_STAGES-1];
            dec_prev <= dec_sync[SYNC_STAGES-1];
        end
    end

    assign inc_pulse = inc_sync[SYNC_STAGES-1] & ~inc_prev;
    assign dec_pulse = dec_sync[SYNC_STAGES-1] & ~dec_prev;

    // Saturating duty request update; the sum is one bit wider so it cannot wrap
    always_comb begin
        duty_req_next = duty_req;
        inc_sum       = {1'b0, duty_req} + STEP_W;
        if (inc_pulse && !dec_pulse) begin
            if (inc_sum > PERIOD_W) begin
                duty_req_next = PERIOD_N;
            end else begin
                duty_req_next = inc_sum[DW-1:0];
            end
        end else if (dec_pulse && !inc_pulse) begin
            if ({1'b0, duty_req} >= STEP_W) begin
                duty_req_next = duty_req - STEP_W[DW-1:0];
            end else begin
                duty_req_next = '0;
            end
        end
    end

    // Period counter next value and the duty that takes effect at the wrap
    always_comb begin
        wrap             = (cnt == CNT_LAST);
        cnt_next         = wrap ? '0 : cnt + 1'b1;
        duty_active_next = wrap ? duty_req_next : duty_active;
    end

    // Registered state: duty request, applied duty, period counter and output
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_req    <= INIT_N;
            duty_active <= INIT_N;
            cnt         <= '0;
            pwm_out     <= 1'b0;
        end else begin
            duty_req    <= duty_req_next;
            duty_active <= duty_active_next;
            cnt         <= cnt_next;
            pwm_out     <= (DW'(cnt_next) < duty_active_next);
        end
    end

endmodule

// File: tb/tb_pwm_duty_gen.sv
// tb/tb_pwm_duty_gen.sv - randomized and directed check of pwm_duty_gen against a reference model
`timescale 1ns/1ps
module tb_pwm_duty_gen;

    localparam int P    = 10;
    localparam int INIT = 5;
    localparam int STEP = 1;
    localparam int S    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic increse_duty = 1'b0;
    logic decrease_duty = 1'b0;
    logic pwm_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    pwm_duty_gen #(
        .PERIOD(P),
        .DUTY_INIT(INIT),
        .DUTY_STEP(STEP),
        .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .increse_duty(increse_duty),
        .decrease_duty(decrease_duty),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a press sampled as a rising edge at cycle E changes the
    // requested duty at cycle E+S; the requested duty is applied when a period ends
    int cyc = 0;
    int m_cnt = 0;
    int m_req = INIT;
    int m_act = INIT;
    int m_pwm = 0;
    bit last_inc = 1'b0;
    bit last_dec = 1'b0;
    int inc_q[$];
    int dec_q[$];
    bit pi, pd;
    int req, nc, act;

    always @(posedge clk) begin
        if (rst) begin
            inc_q.delete();
            dec_q.delete();
            m_cnt    <= 0;
            m_req    <= INIT;
            m_act    <= INIT;
            m_pwm    <= 0;
            last_inc <= 1'b0;
            last_dec <= 1'b0;
        end else begin
            pi = 1'b0;
            pd = 1'b0;
            if (inc_q.size() > 0 && inc_q[0] == cyc) begin
                pi = 1'b1;
                void'(inc_q.pop_front());
            end
            if (dec_q.size() > 0 && dec_q[0] == cyc) begin
                pd = 1'b1;
                void'(dec_q.pop_front());
            end
            if (increse_duty && !last_inc) inc_q.push_back(cyc + S);
            if (decrease_duty && !last_dec) dec_q.push_back(cyc + S);
            req = m_req;
            if (pi && !pd) req = (req + STEP > P) ? P : req + STEP;
            else if (pd && !pi) req = (req >= STEP) ? req - STEP : 0;
            nc  = (m_cnt + 1) % P;
            act = (nc == 0) ? req : m_act;
            m_cnt    <= nc;
            m_req    <= req;
            m_act    <= act;
            m_pwm    <= (nc < act) ? 1 : 0;
            last_inc <= increse_duty;
            last_dec <= decrease_duty;
        end
        cyc <= cyc + 1;
    end

    // Cycle-by-cycle comparison of the output against the model
    always @(negedge clk) begin
        if (chk_en) check("pwm_cycle", int'(pwm_out), m_pwm);
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic press(input bit inc, input bit dec, input int hi, input int lo);
        @(negedge clk);
        increse_duty  = inc;
        decrease_duty = dec;
        idle(hi);
        increse_duty  = 1'b0;
        decrease_duty = 1'b0;
        idle(lo);
    endtask

    // High cycles over any full period of a steady waveform equal the duty
    task automatic measure(input string tag, input int exp);
        int highs;
        highs = 0;
        idle(25);
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) highs++;
        end
        check(tag, highs, exp);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("pwm_in_reset", int'(pwm_out), 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        do_reset(2);
        chk_en = 1'b1;
        @(negedge clk);
        check("first_after_reset", int'(pwm_out), 1);
        measure("duty_reset", 5);

        press(1'b1, 1'b0, 2, 3);
        measure("duty_inc", 6);
        press(1'b1, 1'b0, 30, 3);
        measure("duty_hold", 7);

        for (int k = 0; k < 6; k++) press(1'b1, 1'b0, 2, 5);
        measure("duty_sat", 10);
        press(1'b1, 1'b0, 2, 5);
        measure("duty_sat_more", 10);

        press(1'b0, 1'b1, 2, 5);
        measure("duty_dec_full", 9);

        do_reset(1);
        for (int k = 0; k < 6; k++) press(1'b0, 1'b1, 2, 5);
        measure("duty_zero", 0);
        press(1'b0, 1'b1, 2, 5);
        measure("duty_zero_more", 0);

        do_reset(1);
        press(1'b1, 1'b1, 3, 3);
        measure("duty_both", 5);

        guard = 0;
        while (m_cnt != 9 && guard < 3 * P) begin
            @(negedge clk);
            guard++;
        end
        check("wait_cnt9", int'(m_cnt == 9), 1);
        increse_duty = 1'b1;
        idle(2);
        increse_duty = 1'b0;
        measure("duty_at_wrap", 6);

        press(1'b1, 1'b0, 2, 3);
        press(1'b1, 1'b0, 2, 3);
        measure("duty_eight", 8);
        guard = 0;
        while (m_cnt != 4 && guard < 3 * P) begin
            @(negedge clk);
            guard++;
        end
        check("wait_cnt4", int'(m_cnt == 4), 1);
        do_reset(2);
        measure("duty_after_mid_reset", 5);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) increse_duty  = ~increse_duty;
            if ($urandom_range(0, 5) == 0) decrease_duty = ~decrease_duty;
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            else rst = 1'b0;
        end
        rst = 1'b0;
        increse_duty = 1'b0;
        decrease_duty = 1'b0;
        idle(30);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_gen.md
# pwm_duty_gen

Fixed-period PWM generator whose duty cycle is stepped up or down at run time by two push-button style request inputs. Each request input is synchronised and rising-edge detected, so one press changes the duty by exactly one step, however long the input is held. Duty changes are applied only at period boundaries, so the output never produces a truncated or glitched pulse. The block sits between user or control inputs and a power stage or LED driver.

## Interface
- PERIOD, default 10: PWM period in clock cycles, at least 2.
- DUTY_INIT, default 5: duty loaded at reset, in high cycles per period, range 0..PERIOD.
- DUTY_STEP, default 1: change in duty per accepted press, at least 1.
- SYNC_STAGES, default 2: flip-flop stages in each input synchroniser, at least 1.

- clk, input, 1: sole clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- increse_duty, input, 1: increase-duty request; asynchronous or level input, and each rising edge counts once.
- decrease_duty, input, 1: decrease-duty request; same rules as increse_duty.
- pwm_out, output, 1: registered PWM waveform.

## Operation
- Synchroniser: each request input passes through SYNC_STAGES flip-flops, followed by one flip-flop that holds the previous synchronised value.
- Edge detect: inc_pulse = sync_inc & ~prev_inc, and dec_pulse is formed the same way. Each pulse lasts one cycle per rising edge of its input.
- duty_req register, width clog2(PERIOD+1), reset to DUTY_INIT:
  - inc_pulse only: duty_req becomes min(duty_req + DUTY_STEP, PERIOD). Compute the sum one bit wider so it cannot overflow.
  - dec_pulse only: duty_req becomes duty_req − DUTY_STEP if duty_req ≥ DUTY_STEP, else 0.
  - Both pulses in the same cycle: no change.
  - Neither pulse: hold.
- Period counter cnt, width clog2(PERIOD), reset to 0: counts 0..PERIOD−1, then wraps to 0.
- duty_active register, reset to DUTY_INIT:
  - Loads duty_req on the edge where cnt wraps from PERIOD−1 to 0.
  - If duty_req updates on that same edge, duty_active takes the new value (the forwarded next value of duty_req).
- Output rule: pwm_out is registered and updated on the same edge as cnt.
  - pwm_out = (cnt_next < duty_active_next).
  - pwm_out is therefore high for the first duty_active cycles of each period.
- Boundary duties:
  - duty 0: pwm_out is constantly 0.
  - duty PERIOD: pwm_out is constantly 1.
  - Saturation is silent; there is no error flag.

## Timing
- While rst is high at an edge, all registers load their reset values on that edge:
  - cnt = 0, duty_req = duty_active = DUTY_INIT, all synchroniser and edge flops = 0.
  - pwm_out = 0, including when DUTY_INIT > 0.
- First cycle after reset release: cnt = 1, and pwm_out = (1 < DUTY_INIT).
- Reset asserted mid-period discards any pending duty change and restarts the period.
- Press latency:
  - Let edge E be the first rising edge at which the input is sampled high.
  - duty_req updates on edge E + SYNC_STAGES.
- Apply latency: duty_active updates at the next wrap edge after the duty_req update, and the same cycle pwm_out reflects it. Worst case is PERIOD cycles.
- Minimum press: the input must be high at one rising edge and low at one rising edge between presses. Shorter glitches may be missed.
- Multiple presses within one period accumulate in duty_req; only the final value is applied at the wrap.

## Test plan
- Reset with defaults: assert rst for 2 cycles, then release. pwm_out must be high for 5 cycles and low for 5 in each 10-cycle period, with the first period starting right after release.
- Increment: pulse increse_duty once for 2 clk cycles. From the next period boundary the waveform must be 6 cycles high and 4 low. Holding the input high for 30 cycles must still give only +1.
- Saturation: apply 6 separate increase presses, each 2 cycles high with 5 cycles between. duty must end at 10 and pwm_out must stay constantly 1. A 7th press must leave the waveform unchanged.
- Decrement from full: from duty 10, one decrease press gives 9 high and 1 low. Starting from 5, six presses give duty 0, pwm_out constantly 0, and no wrap-around to a large duty.
- Simultaneous press: raise both inputs on the same edge. duty must stay at 5. Also press increse_duty on the cycle where cnt = 9: the new duty must apply either at that wrap or the next one, and no period may contain a partial pulse.
- Reset mid-operation: set duty to 8, then assert rst while cnt = 4. pwm_out must be 0 during reset, and the 5/5 waveform must resume from the edge after release.
